pipe_ctl: RTL and testbench
===========================

# pipe_ctl

Pipeline hazard controller for the five-stage Y86-64 core. It drives the per-stage `stall`/`bubble` inputs of the pipeline registers and the `set_cc` enable of the condition-code register. Its inputs are the decode and execute stage contents, the branch `Cnd` result, and the memory/writeback status codes. It owns a small FSM that sequences `ret` bubbles and latches the halted state.

## Interface
- `CNT_W`, 32, width of each performance counter (used only with `PIPE_CTL_PERF_EN`).
- `clock`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `d_icode`  in  4  icode in the D register.
- `d_srcA`, `d_srcB`  in  4 each  source register IDs in D; `4'hF` = RNONE.
- `e_icode`  in  4  icode in the E register.
- `e_dstM`  in  4  load destination in the E register.
- `e_cnd`  in  1  `Cnd` from the branch condition logic.
- `m_stat`, `w_stat`  in  3 each  status in M and W (1 AOK, 2 HLT, 3 ADR, 4 INS).
- `f_stall`, `d_stall`, `w_stall`  out  1 each  hold the register.
- `d_bubble`, `e_bubble`, `m_bubble`  out  1 each  load a nop into the register.
- `set_cc`  out  1  condition-code write enable.
- `perf_lu`, `perf_mp`, `perf_ret`  out  `CNT_W` each  event counters.

## Operation
- Icodes: HALT 0, NOP 1, CMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
- **Load-use (LU):** all of the following hold:
  - `e_icode` ∈ {5, B};
  - `e_dstM` ≠ F;
  - `e_dstM` equals `d_srcA` or `d_srcB`.
  - Response: `f_stall` = 1, `d_stall` = 1, `e_bubble` = 1.
- **Mispredict (MP):** `e_icode` = 7 and `e_cnd` = 0 (branches are predicted taken).
  - Response: `d_bubble` = 1, `e_bubble` = 1.
- **Ret (RT):** active when `d_icode` = 9 or the state is RET_WAIT.
  - Response: `f_stall` = 1, `d_bubble` = 1.
- **Priority:** MP > LU > RT.
  - MP with `ret` in D: the `ret` is squashed and RET_WAIT is not entered.
  - LU with `ret` in D: the stall wins; RET_WAIT is entered only on the cycle `ret` leaves D unstalled.
- **Exception:** `m_stat` or `w_stat` ≠ AOK forces:
  - `m_bubble` = 1;
  - `set_cc` = 0.
  - Otherwise `set_cc` = 1 when `e_icode` = 6, else 0.
- **FSM:**
  - RUN → RET_WAIT (`cnt` = 1) on an edge where `d_icode` = 9 and neither MP nor LU holds.
  - RET_WAIT: `cnt` decrements each edge; returns to RUN on the edge where `cnt` = 0.
  - Any state → HALTED on an edge where `w_stat` ≠ AOK.
  - HALTED is sticky until reset. In HALTED:
    - `w_stall` = 1, `f_stall` = 1;
    - `d_bubble` = 1, `e_bubble` = 1, `m_bubble` = 1;
    - `set_cc` = 0.
- Outputs are combinational functions of the current state and inputs, with no added latency.

## Timing
- **Reset low:**
  - state = RUN, `cnt` = 0, counters = 0;
  - `d_bubble` = `e_bubble` = `m_bubble` = 1;
  - all stalls = 0, `set_cc` = 0.
- **Ret sequence:** `ret` is in D at cycle 0, so RT is asserted in cycles 0, 1 and 2. In cycle 3, F fetches using W's valM.
- **Mispredict:** exactly one cycle of D/E bubble per mispredicted `jxx`.
- **Load-use:** exactly one stall cycle. On the following cycle the load is in M and the operand is forwarded.
- **Reset mid-RET_WAIT or in HALTED:** returns to RUN immediately, asynchronously.

## Configuration
- `PIPE_CTL_PERF_EN` defined: three saturating `CNT_W`-bit counters.
  - `perf_lu`: +1 per LU cycle.
  - `perf_mp`: +1 per MP cycle.
  - `perf_ret`: +1 per RT cycle.
  - No counter increments in HALTED.
  - Each counter saturates at all-ones.
- `PIPE_CTL_PERF_EN` undefined: the ports remain, driven constant 0, and no counter flops are instantiated.

## Structure
- Package `pipe_pkg` holds:
  - the icode constants;
  - the stat codes;
  - `RNONE` = `4'hF`;
  - the FSM state enum (RUN, RET_WAIT, HALTED).
- Sub-module `sat_counter` (parameter `CNT_W`; ports `clock`, `reset`, `inc`, `count`) is instantiated three times under the macro.

## Test plan
- **Load-use:** `e_icode` = 5, `e_dstM` = 3, `d_srcA` = 3 → `f_stall` = `d_stall` = `e_bubble` = 1 for one cycle. Repeat with `d_srcB` = F, `d_srcA` = 4 → no stall.
- **Mispredict:** `e_icode` = 7, `e_cnd` = 0 → `d_bubble` = `e_bubble` = 1 for one cycle. With `e_cnd` = 1 → no bubble.
- **Ret:** `d_icode` = 9 for one cycle → `f_stall` = `d_bubble` = 1 for exactly 3 cycles, then 0.
- **Combined:**
  - Case A: `ret` in D with LU in E → stall first, then 3 RT cycles.
  - Case B: `ret` in D with MP → 1 bubble cycle only, no RET_WAIT.
- **Exception/halt:**
  - `m_stat` = 3 → `m_bubble` = 1, `set_cc` = 0.
  - Then `w_stat` = 2 → HALTED with `w_stall` = 1 sticky.
  - Assert `reset` low → all outputs return to their reset values.
- **Perf (macro on):** 4 LU + 2 MP + 1 `ret` → `perf_lu` = 4, `perf_mp` = 2, `perf_ret` = 3. With `CNT_W` = 2 and 5 LU cycles → `perf_lu` holds at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the Y86-64 pipeline hazard controller: icodes,
// status codes, the "no register" ID and the controller FSM states.
`default_nettype none

package pipe_pkg;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_RET_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_ctl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_ctl.sv
// pipe_ctl: stall/bubble/set_cc control for the five-stage Y86-64 pipeline.
// Define PIPE_CTL_PERF_EN to build the load-use / mispredict / ret counters.
`default_nettype none

module pipe_ctl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       d_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       e_icode,
   input  logic [3:0]       e_dstM,
   input  logic             e_cnd,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       w_stat,
   output logic             f_stall,
   output logic             d_stall,
   output logic             w_stall,
   output logic             d_bubble,
   output logic             e_bubble,
   output logic             m_bubble,
   output logic             set_cc,
   output logic [CNT_W-1:0] perf_lu,
   output logic [CNT_W-1:0] perf_mp,
   output logic [CNT_W-1:0] perf_ret
);

   state_t state_q;
   logic   cnt_q;

   logic lu_hz;
   logic mp_hz;
   logic rt_hz;
   logic exc;

   assign lu_hz = ((e_icode == I_MRMOV) || (e_icode == I_POP)) &&
                  (e_dstM != RNONE) &&
                  ((e_dstM == d_srcA) || (e_dstM == d_srcB));
   assign mp_hz = (e_icode == I_JXX) && !e_cnd;
   assign rt_hz = (d_icode == I_RET) || (state_q == ST_RET_WAIT);
   assign exc   = (m_stat != S_AOK) || (w_stat != S_AOK);

   // A ret only starts its wait once it leaves D unstalled and unsquashed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 1'b0;
      end else if (w_stat != S_AOK) begin
         state_q <= ST_HALTED;
      end else begin
         case (state_q)
            ST_RUN: begin
               if ((d_icode == I_RET) && !mp_hz && !lu_hz) begin
                  state_q <= ST_RET_WAIT;
                  cnt_q   <= 1'b1;
               end
            end
            ST_RET_WAIT: begin
               if (cnt_q == 1'b0) begin
                  state_q <= ST_RUN;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_HALTED: state_q <= ST_HALTED;
            default:   state_q <= ST_RUN;
         endcase
      end
   end

   always_comb begin
      f_stall  = 1'b0;
      d_stall  = 1'b0;
      w_stall  = 1'b0;
      d_bubble = 1'b0;
      e_bubble = 1'b0;
      m_bubble = 1'b0;
      set_cc   = 1'b0;
      if (!reset) begin
         d_bubble = 1'b1;
         e_bubble = 1'b1;
         m_bubble = 1'b1;
      end else if (state_q == ST_HALTED) begin
         w_stall  = 1'b1;
         f_stall  = 1'b1;
         d_bubble = 1'b1;
         e_bubble = 1'b1;
         m_bubble = 1'b1;
      end else begin
         if (mp_hz) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
         end else if (lu_hz) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
         end else if (rt_hz) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
         end
         m_bubble = exc;
         set_cc   = !exc && (e_icode == I_OPQ);
      end
   end

`ifdef PIPE_CTL_PERF_EN
   // Counters record the hazard that actually won priority this cycle.
   logic cnt_en;
   assign cnt_en = (state_q != ST_HALTED);

   sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (
      .clock (clock),
      .reset (reset),
      .inc   (cnt_en && lu_hz && !mp_hz),
      .count (perf_lu)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_mp (
      .clock (clock),
      .reset (reset),
      .inc   (cnt_en && mp_hz),
      .count (perf_mp)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_ret (
      .clock (clock),
      .reset (reset),
      .inc   (cnt_en && rt_hz && !mp_hz && !lu_hz),
      .count (perf_ret)
   );
`else
   assign perf_lu  = '0;
   assign perf_mp  = '0;
   assign perf_ret = '0;
`endif

endmodule : pipe_ctl

`default_nettype wire

// File: tb/tb_pipe_ctl.sv
// Randomised + directed scoreboard bench for pipe_ctl (CNT_W = 32 and 2).
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_ctl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] d_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF;
   logic [3:0] e_icode = 4'h1, e_dstM = 4'hF;
   logic       e_cnd = 1'b0;
   logic [2:0] m_stat = 3'd1, w_stat = 3'd1;

   logic        f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc;
   logic [31:0] perf_lu, perf_mp, perf_ret;
   logic        f_stall2, d_stall2, w_stall2, d_bubble2, e_bubble2, m_bubble2, set_cc2;
   logic [1:0]  perf_lu2, perf_mp2, perf_ret2;

   pipe_ctl #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset),
      .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
      .m_stat(m_stat), .w_stat(w_stat),
      .f_stall(f_stall), .d_stall(d_stall), .w_stall(w_stall),
      .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble),
      .set_cc(set_cc),
      .perf_lu(perf_lu), .perf_mp(perf_mp), .perf_ret(perf_ret)
   );

   pipe_ctl #(.CNT_W(2)) dut2 (
      .clock(clock), .reset(reset),
      .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
      .m_stat(m_stat), .w_stat(w_stat),
      .f_stall(f_stall2), .d_stall(d_stall2), .w_stall(w_stall2),
      .d_bubble(d_bubble2), .e_bubble(e_bubble2), .m_bubble(m_bubble2),
      .set_cc(set_cc2),
      .perf_lu(perf_lu2), .perf_mp(perf_mp2), .perf_ret(perf_ret2)
   );

   always #5 clock = ~clock;

   // ctl order: {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc}
   typedef struct {
      logic [6:0] ctl;
      longint     lu;
      longint     mp;
      longint     rt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: halted flag, cycles of RT still owed after ret left D,
   // and raw event counts.
   bit     m_halt    = 1'b0;
   int     m_ret_rem = 0;
   longint c_lu = 0, c_mp = 0, c_rt = 0;

   function automatic longint sat(input longint c, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic cyc(input logic r, input logic [3:0] di, input logic [3:0] sa,
                      input logic [3:0] sb, input logic [3:0] ei, input logic [3:0] edm,
                      input logic ec, input logic [2:0] ms, input logic [2:0] ws);
      exp_t e;
      bit mp, lu, rt, exc;
      @(posedge clock);
      #1;
      reset = r; d_icode = di; d_srcA = sa; d_srcB = sb;
      e_icode = ei; e_dstM = edm; e_cnd = ec; m_stat = ms; w_stat = ws;

      mp  = (ei == 4'd7) && !ec;
      lu  = ((ei == 4'd5) || (ei == 4'd11)) && (edm != 4'hF) && ((edm == sa) || (edm == sb));
      rt  = (di == 4'd9) || (m_ret_rem > 0);
      exc = (ms != 3'd1) || (ws != 3'd1);

      if (!r) begin
         m_halt = 1'b0; m_ret_rem = 0; c_lu = 0; c_mp = 0; c_rt = 0;
         e.ctl = 7'b000_1110;
      end else if (m_halt) begin
         e.ctl = 7'b101_1110;
      end else begin
         e.ctl[6] = !mp && (lu || rt);
         e.ctl[5] = !mp && lu;
         e.ctl[4] = 1'b0;
         e.ctl[3] = mp || (!lu && rt);
         e.ctl[2] = mp || lu;
         e.ctl[1] = exc;
         e.ctl[0] = !exc && (ei == 4'd6);
      end
      e.lu = c_lu; e.mp = c_mp; e.rt = c_rt;
      sb_q.push_back(e);

      if (r) begin
         if (!m_halt) begin
            if (mp)            c_mp++;
            else if (lu)       c_lu++;
            else if (rt)       c_rt++;
         end
         if (m_halt) begin
         end else if (ws != 3'd1) begin
            m_halt = 1'b1;
         end else if (m_ret_rem > 0) begin
            m_ret_rem--;
         end else if ((di == 4'd9) && !mp && !lu) begin
            m_ret_rem = 2;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 3'd1, 3'd1);
   endtask

   // Monitor: every cycle the DUT presents a fresh set of control outputs.
   initial begin : monitor
      exp_t e;
      logic [6:0] got, got2;
      longint x_lu, x_mp, x_rt, y_lu, y_mp, y_rt;
      forever begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            got  = {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc};
            got2 = {f_stall2, d_stall2, w_stall2, d_bubble2, e_bubble2, m_bubble2, set_cc2};
`ifdef PIPE_CTL_PERF_EN
            x_lu = sat(e.lu, 32); x_mp = sat(e.mp, 32); x_rt = sat(e.rt, 32);
            y_lu = sat(e.lu, 2);  y_mp = sat(e.mp, 2);  y_rt = sat(e.rt, 2);
`else
            x_lu = 0; x_mp = 0; x_rt = 0; y_lu = 0; y_mp = 0; y_rt = 0;
`endif
            n_checks++;
            if (got === e.ctl) n_pass++;
            else $display("FAIL ctl @%0t: got %b expected %b", $time, got, e.ctl);
            n_checks++;
            if (got2 === e.ctl) n_pass++;
            else $display("FAIL ctl_w2 @%0t: got %b expected %b", $time, got2, e.ctl);
            n_checks++;
            if (longint'(perf_lu) == x_lu && longint'(perf_mp) == x_mp &&
                longint'(perf_ret) == x_rt) n_pass++;
            else $display("FAIL perf32 @%0t: got lu=%0d mp=%0d ret=%0d expected lu=%0d mp=%0d ret=%0d",
                          $time, perf_lu, perf_mp, perf_ret, x_lu, x_mp, x_rt);
            n_checks++;
            if (longint'(perf_lu2) == y_lu && longint'(perf_mp2) == y_mp &&
                longint'(perf_ret2) == y_rt) n_pass++;
            else $display("FAIL perf2 @%0t: got lu=%0d mp=%0d ret=%0d expected lu=%0d mp=%0d ret=%0d",
                          $time, perf_lu2, perf_mp2, perf_ret2, y_lu, y_mp, y_rt);
         end
      end
   end

   initial begin : stim
      logic [3:0] di, sa, sb, ei, edm;
      logic [2:0] ms, ws;
      logic       r;
      int         k;

      cyc(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 3'd1, 3'd1);
      cyc(0, 4'h6, 4'h3, 4'h3, 4'h5, 4'h3, 0, 3'd1, 3'd1);
      idle(2);
      // load-use hit, then miss with srcB = RNONE
      cyc(1, 4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 0, 3'd1, 3'd1);
      cyc(1, 4'h6, 4'h3, 4'hF, 4'h1, 4'hF, 0, 3'd1, 3'd1);
      cyc(1, 4'h6, 4'h4, 4'hF, 4'h5, 4'h3, 0, 3'd1, 3'd1);
      // mispredict, then correctly predicted branch; OPQ in E sets cc
      cyc(1, 4'h6, 4'hF, 4'hF, 4'h7, 4'hF, 0, 3'd1, 3'd1);
      cyc(1, 4'h6, 4'hF, 4'hF, 4'h7, 4'hF, 1, 3'd1, 3'd1);
      cyc(1, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 3'd1, 3'd1);
      // lone ret
      cyc(1, 4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 0, 3'd1, 3'd1);
      idle(4);
      // case A: ret in D with load-use in E
      cyc(1, 4'h9, 4'h4, 4'h4, 4'hB, 4'h4, 0, 3'd1, 3'd1);
      cyc(1, 4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 0, 3'd1, 3'd1);
      idle(4);
      // case B: ret in D squashed by mispredict
      cyc(1, 4'h9, 4'h4, 4'h4, 4'h7, 4'hF, 0, 3'd1, 3'd1);
      idle(3);
      // five back-to-back load-use cycles saturate the 2-bit counter
      for (k = 0; k < 5; k++) cyc(1, 4'h6, 4'h2, 4'h7, 4'h5, 4'h7, 0, 3'd1, 3'd1);
      idle(1);
      // exception in M, then halt from W, sticky, then reset
      cyc(1, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 3'd3, 3'd1);
      cyc(1, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 3'd1, 3'd2);
      cyc(1, 4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 0, 3'd1, 3'd1);
      cyc(1, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 0, 3'd1, 3'd1);
      cyc(0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 3'd1, 3'd1);
      idle(2);
      // reset while in RET_WAIT
      cyc(1, 4'h9, 4'h4, 4'hF, 4'h1, 4'hF, 0, 3'd1, 3'd1);
      cyc(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 3'd1, 3'd1);
      idle(3);

      for (int i = 0; i < 400; i++) begin
         di  = 4'($urandom_range(0, 11));
         sa  = 4'($urandom_range(0, 15));
         sb  = 4'($urandom_range(0, 15));
         ei  = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 2) == 0) ei = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'hB;
         edm = ($urandom_range(0, 1) == 0) ? sa : 4'($urandom_range(0, 15));
         ms  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
         ws  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
         r   = !((i % 60 == 59) || (m_halt && ($urandom_range(0, 3) == 0)));
         cyc(r, di, sa, sb, ei, edm, 1'($urandom_range(0, 1)), ms, ws);
      end

      for (k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clock);
      #1;
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pipe_ctl

`default_nettype wire
